gate_identifier: RTL

- Sequential inverse of the two-input gate library: drive (a,b) pairs, observe the outputs of an unknown gate, and identify which of the 8 library functions produced them.
- Used as a self-check / black-box classifier next to the gate library, e.g. in the gates bring-up bench and the BIST wrapper.
- Samples arrive over a valid/ready handshake.
- The block narrows a candidate mask and reports a gate ID, or an error / ambiguous result.

---
 rtl/gate_id_pkg.sv | 45 ++++
 rtl/gate_consistency.sv | 25 ++
 rtl/gate_identifier.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gate_id_pkg.sv
// Shared constants for the gate identifier: result codes, FSM encoding,
// the two-input gate truth table and small mask helpers.
package gate_id_pkg;

  localparam logic [3:0] GID_AND   = 4'd0;
  localparam logic [3:0] GID_NAND  = 4'd1;
  localparam logic [3:0] GID_OR    = 4'd2;
  localparam logic [3:0] GID_NOR   = 4'd3;
  localparam logic [3:0] GID_XOR   = 4'd4;
  localparam logic [3:0] GID_XNOR  = 4'd5;
  localparam logic [3:0] GID_INV   = 4'd6;
  localparam logic [3:0] GID_BUF   = 4'd7;
  localparam logic [3:0] GID_AMBIG = 4'hE;
  localparam logic [3:0] GID_NONE  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Entry {a,b} holds every gate's output for that input pair, bit i = gate code i.
  localparam logic [3:0][7:0] GATE_TT = {8'hA5, 8'h96, 8'h56, 8'h6A};

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [3:0] onehot_index8(input logic [7:0] v);
    logic [3:0] idx;
    idx = GID_NONE;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/gate_consistency.sv
// Combinational consistency vector: bit i is set when gate code i, driven
// with (a_i,b_i), would have produced the observed y_i.
module gate_consistency
  import gate_id_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       y_i,
  output logic [7:0] cons_o
);

  logic [7:0] gate_y_s;

  and  u_and  (gate_y_s[GID_AND[2:0]],  a_i, b_i);
  nand u_nand (gate_y_s[GID_NAND[2:0]], a_i, b_i);
  or   u_or   (gate_y_s[GID_OR[2:0]],   a_i, b_i);
  nor  u_nor  (gate_y_s[GID_NOR[2:0]],  a_i, b_i);
  xor  u_xor  (gate_y_s[GID_XOR[2:0]],  a_i, b_i);
  xnor u_xnor (gate_y_s[GID_XNOR[2:0]], a_i, b_i);
  not  u_inv  (gate_y_s[GID_INV[2:0]],  a_i);
  buf  u_buf  (gate_y_s[GID_BUF[2:0]],  a_i);

  assign cons_o = ~(gate_y_s ^ {8{y_i}});

endmodule

// File: rtl/gate_identifier.sv
// Black-box classifier for the two-input gate library: narrows a candidate
// mask from (a,b,y) samples. Optional conflict detection under GATE_ID_CONFLICT_EN.
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int unsigned MAX_SAMPLES = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             y_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [3:0]       gate_id_out,
  output logic [7:0]       match_mask_out,
  output logic [3:0]       coverage_out,
  output logic [CNT_W-1:0] sample_cnt_out,
  output logic             error_out
`ifdef GATE_ID_CONFLICT_EN
  ,
  output logic             conflict_out
`endif
);

  state_e           state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [3:0]       cov_q, cov_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       id_q, id_d;
  logic             err_q, err_d;
  logic             ready_q, busy_q, done_q;
  logic             conf_q, conf_d;
  logic             accept_s, conflict_s;
  logic [1:0]       combo_s;
  logic [3:0]       sel_s;
  logic [7:0]       cons_s;

  gate_consistency u_cons (
    .a_i    (a_in),
    .b_i    (b_in),
    .y_i    (y_in),
    .cons_o (cons_s)
  );

  assign accept_s = valid_in && ready_q;
  assign combo_s  = {a_in, b_in};
  assign sel_s    = 4'b0001 << combo_s;

`ifdef GATE_ID_CONFLICT_EN
  logic [3:0] ytab_q, ytab_d;

  // A covered combination seen again with a different y is a contradiction.
  assign conflict_s = ((cov_q & sel_s) != 4'h0) && (ytab_q[combo_s] != y_in);

  always_comb begin
    ytab_d = ytab_q;
    if (state_q == ST_COLLECT && accept_s) begin
      ytab_d = (ytab_q & ~sel_s) | (y_in ? sel_s : 4'h0);
    end else if (state_q != ST_COLLECT && start_in) begin
      ytab_d = 4'h0;
    end else begin
      ytab_d = ytab_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ytab_q <= 4'h0;
    end else begin
      ytab_q <= ytab_d;
    end
  end

  assign conflict_out = conf_q;
`else
  assign conflict_s = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cov_d   = cov_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    err_d   = err_q;
    conf_d  = conf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          state_d = ST_COLLECT;
          mask_d  = 8'hFF;
          cov_d   = 4'h0;
          cnt_d   = '0;
          id_d    = GID_NONE;
          err_d   = 1'b0;
          conf_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_COLLECT: begin
        if (accept_s) begin
          mask_d = mask_q & cons_s;
          cov_d  = cov_q | sel_s;
          cnt_d  = cnt_q + CNT_W'(1);
          // Finish checks look at the post-accept mask and count.
          if (conflict_s) begin
            state_d = ST_DONE;
            id_d    = GID_NONE;
            err_d   = 1'b1;
            conf_d  = 1'b1;
          end else if (popcount8(mask_d) == 4'd1) begin
            state_d = ST_DONE;
            id_d    = onehot_index8(mask_d);
          end else if (mask_d == 8'h00) begin
            state_d = ST_DONE;
            id_d    = GID_NONE;
            err_d   = 1'b1;
          end else if (cnt_d == CNT_W'(MAX_SAMPLES)) begin
            state_d = ST_DONE;
            id_d    = GID_AMBIG;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      mask_q  <= 8'hFF;
      cov_q   <= 4'h0;
      cnt_q   <= '0;
      id_q    <= GID_NONE;
      err_q   <= 1'b0;
      conf_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cov_q   <= cov_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      err_q   <= err_d;
      conf_q  <= conf_d;
      ready_q <= (state_d == ST_COLLECT);
      busy_q  <= (state_d == ST_COLLECT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign ready_out      = ready_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign gate_id_out    = id_q;
  assign match_mask_out = mask_q;
  assign coverage_out   = cov_q;
  assign sample_cnt_out = cnt_q;
  assign error_out      = err_q;

endmodule
